uart_rx_core: RTL and testbench
===============================

# uart_rx_core

8N1 UART receiver: the receive end of the serial link whose transmit end is the CPU's `uart_tx` pin. It recovers bytes from an asynchronous serial line and presents them on a one-entry valid/ready holding register. Typical consumers are a host-command or program-load path, or a loopback checker in the test harness. It reports framing errors and overruns as single-cycle pulses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434, clock cycles per bit (50 MHz / 115200). Legal values are ≥ 4.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `rx`, in, 1: serial line. Idle is high. Asynchronous to `clk`.
- `rx_data`, out, 8: received byte, valid while `rx_valid`=1.
- `rx_valid`, out, 1: the holding register is full.
- `rx_ready`, in, 1: the consumer accepts the byte.
- `busy`, out, 1: a frame is in progress (state ≠ IDLE).
- `frame_err`, out, 1: one-cycle pulse, stop bit sampled low.
- `overrun`, out, 1: one-cycle pulse, good frame dropped because the holding register was full.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer. Both flops reset to 1. The synchronized value is `rxs`.
  - There is no further filtering; mid-bit sampling gives glitch rejection.
- Counter: `bit_cnt` down-counter, width $clog2(CLKS_PER_BIT). H = CLKS_PER_BIT/2 (floor).
- States:
  - IDLE: when `rxs`=0, load counter H-1 and go to START.
  - START: count down. At 0, sample `rxs`.
    - If 0: load counter CLKS_PER_BIT-1, clear bit index, go to DATA.
    - If 1: false start; go to IDLE with no output.
  - DATA: count down. At 0, shift `rxs` into the shift register, LSB first (shift right, new bit into bit 7), reload CLKS_PER_BIT-1 and increment the index. After the 8th sample go to STOP.
  - STOP: count down. At 0, sample `rxs`.
    - If 1 (good frame): deliver the byte (see holding register) and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This blocks false starts during a held-low line.
- Holding register:
  - A good frame loads `rx_data` and sets `rx_valid` if either:
    - `rx_valid`=0, or
    - `rx_valid`&`rx_ready` on the same edge (simultaneous consume and load: `rx_valid` stays 1 and `rx_data` takes the new byte).
  - Otherwise `rx_data` is unchanged, the new byte is dropped, and `overrun` pulses.
  - `rx_valid`&`rx_ready` with no load clears `rx_valid` on that edge.
  - `rx_data` holds its value after consumption and is not cleared.
- `frame_err` and `overrun` are registered and never assert in the same cycle.

## Timing
- Reset values:
  - `rx_data`=0x00; `rx_valid`, `busy`, `frame_err`, `overrun` = 0.
  - State IDLE; synchronizer = 1.
  - Reset is asynchronous: outputs clear immediately when `rst_n` falls, regardless of state. This includes mid-frame reset, where the partial byte is lost.
- Latency, with edge E defined as the first cycle `rxs`=0 in IDLE (2 cycles after `rx` falls):
  - Start sample at E+H.
  - Data bit i (0..7) sampled at E+H+(i+1)·CLKS_PER_BIT.
  - Stop sampled at E+H+9·CLKS_PER_BIT.
  - `rx_valid`, `frame_err` and `overrun` are visible the cycle after the stop sample.
- `busy` rises the cycle after E. It falls the cycle after the stop sample on a good frame, or after `rxs` returns high from BREAK.
- IDLE is re-entered in mid stop bit, so back-to-back frames with zero idle time are received.
- Handshake: the transfer occurs on a rising edge with `rx_valid`&`rx_ready`. `rx_ready` may be tied high. `rx_ready` has no effect while `rx_valid`=0.

## Test plan
All scenarios use CLKS_PER_BIT=8, so H=4.
- Reset with `rx`=1 held → all outputs 0 and `rx_data`=0x00. Assert `rst_n` low mid-frame → outputs clear immediately.
- Send 0xA5, `rx_ready`=0 → `rx_valid`=1 at E+77 with `rx_data`=0xA5 and no pulses. Then pulse `rx_ready` for one cycle → `rx_valid`=0 the next cycle while `rx_data` stays 0xA5.
- `rx` low for 2 cycles, then high → no `rx_valid`; `busy` returns to 0 at E+5; no `frame_err`.
- Send 0x3C with the stop bit low and `rx` held low 20 more cycles → exactly one `frame_err` pulse, `rx_valid`=0, no new frame until `rx` goes high. A following 0x55 frame is received correctly.
- Send 0x11 then 0x22 back-to-back, `rx_ready`=0 → `rx_data`=0x11 and one `overrun` pulse after the second stop bit. With `rx_ready` tied high instead → 0x11 then 0x22 each delivered with no overrun.
- Drop `rst_n` during bit 3 of 0x5A, release it, then send a full 0x5A → a single `rx_valid` with `rx_data`=0x5A; no `frame_err`.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling FSM,
// one-entry valid/ready holding register with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state;
  logic            rx_meta;
  logic            rxs;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            cnt_zero;

  always_comb begin
    cnt_zero = (bit_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consume first; a load in STOP below overrides this on the same edge.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            bit_cnt <= HALF_M1;
            state   <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt_zero) begin
            if (!rxs) begin
              bit_cnt <= FULL_M1;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt_zero) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= FULL_M1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt_zero) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected events,
// a negedge monitor pops and compares every delivery and error pulse.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CPB = 8;
  localparam int EV_DATA = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  bit  held = 0;
  bit  prev_valid = 0;
  bit  prev_hs = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h expected none at %0t", kind, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == EV_DATA && kind == EV_DATA) chk("rx_data", d, e.data);
    end
  endtask

  // Monitor: a new byte is present when rx_valid is seen after an empty
  // register or right after a handshake edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      if (frame_err || overrun) chk("fe_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      if (frame_err) got_ev(EV_FE, 8'h00);
      if (overrun) got_ev(EV_OVR, 8'h00);
      if (rx_valid && (!prev_valid || prev_hs)) got_ev(EV_DATA, rx_data);
      prev_valid = rx_valid;
      prev_hs = rx_valid && rx_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the stop bit ends.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(CPB);
    end
    rx = stop_ok;
    step(CPB);
  endtask

  // Expected outcome of a good frame given holding-register occupancy.
  task automatic expect_good(input logic [7:0] d);
    if (!held) begin
      push_ev(EV_DATA, d);
      held = !rx_ready;
    end else begin
      push_ev(EV_OVR, 8'h00);
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    held = 0;
  endtask

  initial begin
    #2ms;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit r;
    bit bad;

    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(5);
    chk("idle_busy", busy, 1'b0);

    // 0xA5 with exact latency checks against the start-bit edge P0.
    expect_good(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk) chk("busy_before_E", busy, 1'b0);
        @(posedge clk);
        @(negedge clk) chk("busy_after_E", busy, 1'b1);
        repeat (75) @(posedge clk);
        @(negedge clk) chk("valid_before_E77", rx_valid, 1'b0);
        @(posedge clk);
        @(negedge clk) chk("valid_at_E77", rx_valid, 1'b1);
        chk("busy_after_stop", busy, 1'b0);
      end
    join
    step(3);
    consume();
    chk("valid_after_consume", rx_valid, 1'b0);
    chk("data_kept_after_consume", rx_data, 8'hA5);

    // False start: 2 low cycles.
    step(4);
    fork
      begin
        rx = 1'b0;
        step(2);
        rx = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk) chk("false_start_busy_E4", busy, 1'b1);
        @(posedge clk);
        @(negedge clk) chk("false_start_busy_E5", busy, 1'b0);
      end
    join
    step(10);

    // Framing error, line held low, then recovery with 0x55.
    push_ev(EV_FE, 8'h00);
    send_frame(8'h3C, 1'b0);
    step(20);
    chk("break_busy", busy, 1'b1);
    chk("break_no_valid", rx_valid, 1'b0);
    rx = 1'b1;
    step(6);
    chk("break_exit_busy", busy, 1'b0);
    expect_good(8'h55);
    send_frame(8'h55, 1'b1);
    step(3);
    consume();

    // Back-to-back with no consumer: second byte overruns.
    step(5);
    expect_good(8'h11);
    send_frame(8'h11, 1'b1);
    expect_good(8'h22);
    send_frame(8'h22, 1'b1);
    step(3);
    chk("overrun_keeps_first", rx_data, 8'h11);
    consume();

    // Back-to-back with rx_ready tied high.
    rx_ready = 1'b1;
    expect_good(8'h11);
    send_frame(8'h11, 1'b1);
    expect_good(8'h22);
    send_frame(8'h22, 1'b1);
    step(3);
    chk("ready_high_drained", rx_valid, 1'b0);
    rx_ready = 1'b0;

    // Consume and load on the same edge as the stop sample.
    expect_good(8'h77);
    send_frame(8'h77, 1'b1);
    push_ev(EV_DATA, 8'h88);
    fork
      send_frame(8'h88, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    chk("simul_valid_stays", rx_valid, 1'b1);
    chk("simul_new_data", rx_data, 8'h88);

    // Mid-frame asynchronous reset during bit 3 with a byte still held.
    d = 8'h5A;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      step(CPB);
    end
    rx = d[3];
    step(3);
    chk("pre_reset_busy", busy, 1'b1);
    chk("pre_reset_valid", rx_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_valid", rx_valid, 1'b0);
    chk("async_reset_data", rx_data, 8'h00);
    held = 0;
    rx = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(10);
    expect_good(8'h5A);
    send_frame(8'h5A, 1'b1);
    step(3);
    consume();
    step(5);

    // Randomized frames, consumer state and gaps.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 4) == 0);
      rx_ready = r;
      if (r) held = 0;
      if (bad) push_ev(EV_FE, 8'h00);
      else expect_good(d);
      send_frame(d, !bad);
      if (bad) begin
        step($urandom_range(0, 12));
        rx = 1'b1;
        step($urandom_range(2, 10));
      end else begin
        step($urandom_range(0, 10));
      end
    end

    rx_ready = 1'b1;
    step(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
